// File: rtl/pdp8_ram_arb_if.sv
// Requester handshakes and SRAM strobe/address signals of the PDP-8 SRAM arbiter.
// The arbiter connects through the slave modport; requesters and the bench use master.
interface pdp8_ram_arb_if;
  logic        cpu_req;
  logic        cpu_we;
  logic [14:0] cpu_addr;
  logic [11:0] cpu_wdata;
  logic [11:0] cpu_rdata;
  logic        cpu_ack;

  logic        dma_req;
  logic        dma_we;
  logic [14:0] dma_addr;
  logic [11:0] dma_wdata;
  logic [11:0] dma_rdata;
  logic        dma_ack;

  logic [17:0] ram_a;
  logic        ram_oe_n;
  logic        ram_we_n;
  logic        ram1_ce_n;
  logic        ram1_ub_n;
  logic        ram1_lb_n;
  logic        busy;

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output cpu_rdata, cpu_ack,
    input  dma_req, dma_we, dma_addr, dma_wdata,
    output dma_rdata, dma_ack,
    output ram_a, ram_oe_n, ram_we_n, ram1_ce_n, ram1_ub_n, ram1_lb_n, busy
  );

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  cpu_rdata, cpu_ack,
    output dma_req, dma_we, dma_addr, dma_wdata,
    input  dma_rdata, dma_ack,
    input  ram_a, ram_oe_n, ram_we_n, ram1_ce_n, ram1_ub_n, ram1_lb_n, busy
  );
endinterface

// File: rtl/pdp8_ram_arb.sv
// Two-port (CPU/DMA) arbiter and access sequencer for an asynchronous 12-bit-wide SRAM.
// Define ARB_ROUND_ROBIN_EN to replace fixed DMA priority with tie-alternating arbitration.
module pdp8_ram_arb #(
  parameter int unsigned RamWait = 2
) (
  input  logic          clk_i,
  input  logic          rst_i,
  pdp8_ram_arb_if.slave bus,
  inout  wire  [15:0]   ram1_io_io
);

  localparam int unsigned NumWait = (RamWait == 0) ? 1 : RamWait;
  localparam logic [3:0]  LastCnt = 4'(NumWait - 1);

  typedef enum logic [1:0] {StIdle, StSetup, StAccess, StDone} state_e;

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        we_q, we_d;
  logic [14:0] addr_q, addr_d;
  logic [11:0] wdata_q, wdata_d;
  logic        gnt_dma_q, gnt_dma_d;
  logic [11:0] cpu_rdata_q, cpu_rdata_d;
  logic [11:0] dma_rdata_q, dma_rdata_d;
  logic        oe_n_q, oe_n_d;
  logic        we_n_q, we_n_d;
  logic        ce_n_q, ce_n_d;
  logic        io_oe_q, io_oe_d;
  logic        cpu_ack_q, cpu_ack_d;
  logic        dma_ack_q, dma_ack_d;
  logic        busy_q, busy_d;
  logic        pick_dma;
  logic        unused_io;

`ifdef ARB_ROUND_ROBIN_EN
  // Tracks only contested grants, so a lone request never shifts the tie-break.
  logic last_dma_q, last_dma_d;

  always_comb begin
    pick_dma   = bus.dma_req && (!bus.cpu_req || !last_dma_q);
    last_dma_d = last_dma_q;
    if (state_q == StIdle && bus.cpu_req && bus.dma_req) begin
      last_dma_d = pick_dma;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      last_dma_q <= 1'b0;
    end else begin
      last_dma_q <= last_dma_d;
    end
  end
`else
  always_comb begin
    pick_dma = bus.dma_req;
  end
`endif

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    we_d        = we_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    gnt_dma_d   = gnt_dma_q;
    cpu_rdata_d = cpu_rdata_q;
    dma_rdata_d = dma_rdata_q;

    unique case (state_q)
      StIdle: begin
        if (bus.cpu_req || bus.dma_req) begin
          gnt_dma_d = pick_dma;
          we_d      = pick_dma ? bus.dma_we    : bus.cpu_we;
          addr_d    = pick_dma ? bus.dma_addr  : bus.cpu_addr;
          wdata_d   = pick_dma ? bus.dma_wdata : bus.cpu_wdata;
          state_d   = StSetup;
        end
      end
      StSetup: begin
        cnt_d   = '0;
        state_d = StAccess;
      end
      StAccess: begin
        if (cnt_q == LastCnt) begin
          state_d = StDone;
          if (!we_q) begin
            if (gnt_dma_q) dma_rdata_d = ram1_io_io[11:0];
            else           cpu_rdata_d = ram1_io_io[11:0];
          end
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    // Strobes are registered from the next state so the SRAM sees glitch-free edges.
    busy_d    = (state_d != StIdle);
    ce_n_d    = !busy_d;
    oe_n_d    = !((state_d == StSetup || state_d == StAccess) && !we_d);
    we_n_d    = !((state_d == StAccess) && we_d);
    io_oe_d   = busy_d && we_d;
    cpu_ack_d = (state_d == StDone) && !gnt_dma_d;
    dma_ack_d = (state_d == StDone) && gnt_dma_d;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      gnt_dma_q   <= 1'b0;
      cpu_rdata_q <= '0;
      dma_rdata_q <= '0;
      oe_n_q      <= 1'b1;
      we_n_q      <= 1'b1;
      ce_n_q      <= 1'b1;
      io_oe_q     <= 1'b0;
      cpu_ack_q   <= 1'b0;
      dma_ack_q   <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      gnt_dma_q   <= gnt_dma_d;
      cpu_rdata_q <= cpu_rdata_d;
      dma_rdata_q <= dma_rdata_d;
      oe_n_q      <= oe_n_d;
      we_n_q      <= we_n_d;
      ce_n_q      <= ce_n_d;
      io_oe_q     <= io_oe_d;
      cpu_ack_q   <= cpu_ack_d;
      dma_ack_q   <= dma_ack_d;
      busy_q      <= busy_d;
    end
  end

  // io_oe_q is only ever set for writes, so it can never overlap a low oe_n.
  assign ram1_io_io    = io_oe_q ? {4'b0000, wdata_q} : 16'hzzzz;
  assign unused_io     = ^ram1_io_io[15:12];

  assign bus.ram_a     = {3'b000, addr_q};
  assign bus.ram_oe_n  = oe_n_q;
  assign bus.ram_we_n  = we_n_q;
  assign bus.ram1_ce_n = ce_n_q;
  assign bus.ram1_ub_n = ce_n_q;
  assign bus.ram1_lb_n = ce_n_q;
  assign bus.cpu_rdata = cpu_rdata_q;
  assign bus.dma_rdata = dma_rdata_q;
  assign bus.cpu_ack   = cpu_ack_q;
  assign bus.dma_ack   = dma_ack_q;
  assign bus.busy      = busy_q;

endmodule

// File: tb/tb_pdp8_ram_arb.sv
// Bench for pdp8_ram_arb: directed cases plus random CPU/DMA traffic against an SRAM model
// and a transaction-level reference memory; a second instance covers RamWait = 0.
module tb_pdp8_ram_arb;

  localparam int W = 2;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  pdp8_ram_arb_if ifa ();
  pdp8_ram_arb_if ifb ();
  wire [15:0] io_a;
  wire [15:0] io_b;

  pdp8_ram_arb #(.RamWait(W)) dut  (.clk_i(clk), .rst_i(rst), .bus(ifa), .ram1_io_io(io_a));
  pdp8_ram_arb #(.RamWait(0)) dut0 (.clk_i(clk), .rst_i(rst), .bus(ifb), .ram1_io_io(io_b));

  // Asynchronous SRAM model for the main instance.
  logic [11:0] mem [0:32767];
  logic [3:0]  noise;
  logic        hi_ones;
  logic [15:0] sram_dout;
  assign sram_dout = {noise, mem[ifa.ram_a[14:0]]};
  assign io_a = (!ifa.ram_oe_n && !ifa.ram1_ce_n) ? sram_dout : 16'hzzzz;
  always @(posedge clk) begin
    if (!ifa.ram_we_n && !ifa.ram1_ce_n) mem[ifa.ram_a[14:0]] <= io_a[11:0];
    noise <= hi_ones ? 4'hF : 4'($urandom);
  end

  // The RamWait = 0 instance reads an address-derived pattern.
  assign io_b = (!ifb.ram_oe_n && !ifb.ram1_ce_n) ? {4'hA, ifb.ram_a[11:0] ^ 12'o5252} : 16'hzzzz;

  int total = 0;
  int bad   = 0;
  logic [11:0] ref_mem [logic [14:0]];
  logic [11:0] m_rd [2];
  bit          m_last_dma;
  logic [14:0] pool [6];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic bit released(input logic [15:0] v);
    return (v === 16'hzzzz) || (v === 16'h0000);
  endfunction

  task automatic finish_acc(input bit is_dma, input bit we, input logic [14:0] addr,
                            input logic [11:0] wd, input int we_lo, input int oe_lo);
    chk("ack_ram_a", 32'(ifa.ram_a), 32'({3'b000, addr}));
    if (we) begin
      chk("wr_bus", 32'(io_a), 32'({4'h0, wd}));
      chk("wr_we_cycles", we_lo, W);
      chk("wr_oe_cycles", oe_lo, 0);
      ref_mem[addr] = wd;
    end else begin
      m_rd[is_dma] = ref_mem.exists(addr) ? ref_mem[addr] : 12'h000;
      chk("rd_we_cycles", we_lo, 0);
      chk("rd_oe_cycles", oe_lo, W + 1);
    end
    chk("cpu_rdata", 32'(ifa.cpu_rdata), 32'(m_rd[0]));
    chk("dma_rdata", 32'(ifa.dma_rdata), 32'(m_rd[1]));
  endtask

  // One CPU and/or DMA request raised together; the model decides who goes first.
  task automatic access(input bit c_en, input bit c_we, input logic [14:0] c_addr,
                        input logic [11:0] c_wd, input bit d_en, input bit d_we,
                        input logic [14:0] d_addr, input logic [11:0] d_wd);
    bit dma_first;
    bit c_pend, d_pend;
    int k, we_lo, oe_lo, c_slot, d_slot;
    dma_first = d_en;
    if (c_en && d_en) begin
`ifdef ARB_ROUND_ROBIN_EN
      dma_first  = !m_last_dma;
      m_last_dma = dma_first;
`else
      dma_first  = 1'b1;
`endif
    end
    c_slot = (c_en && d_en && dma_first)  ? 2 * W + 5 : W + 2;
    d_slot = (c_en && d_en && !dma_first) ? 2 * W + 5 : W + 2;
    ifa.cpu_we = c_we; ifa.cpu_addr = c_addr; ifa.cpu_wdata = c_wd; ifa.cpu_req = c_en;
    ifa.dma_we = d_we; ifa.dma_addr = d_addr; ifa.dma_wdata = d_wd; ifa.dma_req = d_en;
    c_pend = c_en; d_pend = d_en;
    k = 0; we_lo = 0; oe_lo = 0;
    while ((c_pend || d_pend) && k < 40) begin
      @(negedge clk);
      k++;
      if (k == 1) chk("busy_hi", 32'(ifa.busy), 1);
      if (!ifa.ram_we_n) we_lo++;
      if (!ifa.ram_oe_n) begin
        oe_lo++;
        chk("rd_bus_owner", 32'(io_a), 32'(sram_dout));
      end
      chk("ack_excl", 32'(ifa.cpu_ack & ifa.dma_ack), 0);
      if (k == 2 && !(c_en && d_en)) begin
        ifa.cpu_we = 1'($urandom); ifa.cpu_addr = 15'($urandom); ifa.cpu_wdata = 12'($urandom);
        ifa.dma_we = 1'($urandom); ifa.dma_addr = 15'($urandom); ifa.dma_wdata = 12'($urandom);
      end
      if (ifa.cpu_ack) begin
        chk("cpu_ack_wanted", 32'(c_pend), 1);
        chk("cpu_ack_slot", k, c_slot);
        finish_acc(1'b0, c_we, c_addr, c_wd, we_lo, oe_lo);
        c_pend = 1'b0; ifa.cpu_req = 1'b0; we_lo = 0; oe_lo = 0;
      end
      if (ifa.dma_ack) begin
        chk("dma_ack_wanted", 32'(d_pend), 1);
        chk("dma_ack_slot", k, d_slot);
        finish_acc(1'b1, d_we, d_addr, d_wd, we_lo, oe_lo);
        d_pend = 1'b0; ifa.dma_req = 1'b0; we_lo = 0; oe_lo = 0;
      end
    end
    chk("ack_timeout", 32'(c_pend | d_pend), 0);
    ifa.cpu_req = 1'b0; ifa.dma_req = 1'b0;
    @(negedge clk);
    chk("idle_busy", 32'(ifa.busy), 0);
    chk("idle_bus_rel", 32'(released(io_a)), 1);
    chk("idle_ce_n", 32'(ifa.ram1_ce_n), 1);
  endtask

  initial begin
    int k, n;
    logic [14:0] a;
    logic [11:0] d;
    rst = 1'b1; hi_ones = 1'b0; m_last_dma = 1'b0; m_rd[0] = '0; m_rd[1] = '0;
    ifa.cpu_req = 0; ifa.cpu_we = 0; ifa.cpu_addr = '0; ifa.cpu_wdata = '0;
    ifa.dma_req = 0; ifa.dma_we = 0; ifa.dma_addr = '0; ifa.dma_wdata = '0;
    ifb.cpu_req = 0; ifb.cpu_we = 0; ifb.cpu_addr = '0; ifb.cpu_wdata = '0;
    ifb.dma_req = 0; ifb.dma_we = 0; ifb.dma_addr = '0; ifb.dma_wdata = '0;
    repeat (3) @(negedge clk);
    chk("rst_strobes", 32'({ifa.ram_oe_n, ifa.ram_we_n, ifa.ram1_ce_n, ifa.ram1_ub_n,
                            ifa.ram1_lb_n}), 32'h1F);
    chk("rst_ram_a", 32'(ifa.ram_a), 0);
    chk("rst_misc", 32'({ifa.busy, ifa.cpu_ack, ifa.dma_ack}), 0);
    chk("rst_rdata", 32'({ifa.cpu_rdata, ifa.dma_rdata}), 0);
    chk("rst_bus_rel", 32'(released(io_a)), 1);
    rst = 1'b0;
    @(negedge clk);

    // Write then read back through an all-ones upper nibble.
    access(1, 1, 15'o10017, 12'o7654, 0, 0, '0, '0);
    hi_ones = 1'b1;
    access(1, 0, 15'o10017, 12'o0000, 0, 0, '0, '0);
    hi_ones = 1'b0;

    for (int i = 0; i < 6; i++) begin
      pool[i] = 15'($urandom);
      access(i[0] == 1'b0, 1, pool[i], 12'($urandom), i[0] == 1'b1, 1, pool[i], 12'($urandom));
    end

    // Simultaneous reads, twice, to exercise the tie-break.
    access(1, 0, pool[0], '0, 1, 0, pool[1], '0);
    access(1, 0, pool[2], '0, 1, 0, pool[3], '0);

    // Abort a write in its ACCESS phase.
    ifa.cpu_we = 1; ifa.cpu_addr = 15'o07777; ifa.cpu_wdata = 12'o1234; ifa.cpu_req = 1;
    @(negedge clk);
    @(negedge clk);
    chk("pre_rst_we_n", 32'(ifa.ram_we_n), 0);
    #2 rst = 1'b1;
    #1;
    chk("abort_strobes", 32'({ifa.ram_oe_n, ifa.ram_we_n, ifa.ram1_ce_n, ifa.ram1_ub_n,
                              ifa.ram1_lb_n}), 32'h1F);
    chk("abort_misc", 32'({ifa.busy, ifa.cpu_ack, ifa.dma_ack}), 0);
    chk("abort_bus_rel", 32'(released(io_a)), 1);
    chk("abort_rdata", 32'({ifa.cpu_rdata, ifa.dma_rdata}), 0);
    ifa.cpu_req = 1'b0;
    m_rd[0] = '0; m_rd[1] = '0; m_last_dma = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("abort_no_ack", 32'(ifa.cpu_ack | ifa.dma_ack), 0);
    end

    // Random traffic.
    for (int i = 0; i < 40; i++) begin
      n = $urandom_range(0, 2);
      access(n != 1, 1'($urandom), pool[$urandom_range(0, 5)], 12'($urandom),
             n != 0, 1'($urandom), pool[$urandom_range(0, 5)], 12'($urandom));
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    // RamWait = 0 instance: three held-request reads, then a write.
    a = 15'o12345;
    ifb.cpu_we = 1'b0; ifb.cpu_addr = a; ifb.cpu_req = 1'b1;
    n = 0; k = 0;
    while (n < 3 && k < 40) begin
      @(negedge clk);
      k++;
      if (!ifb.ram_oe_n) chk("b_rd_bus_owner", 32'(io_b), 32'({4'hA, ifb.ram_a[11:0] ^ 12'o5252}));
      if (ifb.cpu_ack) begin
        chk("b_ack_slot", k, 3 + 4 * n);
        chk("b_ram_a", 32'(ifb.ram_a), 32'({3'b000, a}));
        chk("b_rdata", 32'(ifb.cpu_rdata), 32'(a[11:0] ^ 12'o5252));
        n++;
        a = a + 15'o01111;
        ifb.cpu_addr = a;
        if (n == 3) ifb.cpu_req = 1'b0;
      end
    end
    chk("b_rd_count", n, 3);
    ifb.cpu_req = 1'b0;
    @(negedge clk);
    d = 12'o4321;
    ifb.cpu_we = 1'b1; ifb.cpu_wdata = d; ifb.cpu_req = 1'b1;
    n = 0; k = 0;
    while (!ifb.cpu_ack && k < 20) begin
      @(negedge clk);
      k++;
      if (!ifb.ram_we_n) n++;
    end
    chk("b_wr_slot", k, 3);
    chk("b_wr_we_cycles", n, 1);
    chk("b_wr_bus", 32'(io_b), 32'({4'h0, d}));
    ifb.cpu_req = 1'b0;
    @(negedge clk);
    chk("b_idle_busy", 32'(ifb.busy), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pdp8_ram_arb.md
Name: pdp8_ram_arb

Overview:
Arbitrates and sequences the external asynchronous SRAM between two 12-bit requesters: the CPU memory port and a DMA port used by the IDE/front-panel path. It owns the SRAM strobes and the bidirectional data bus. It places a 15-bit PDP-8 extended address (3-bit field + 12-bit word) onto the 18-bit SRAM address. It performs one single-word access at a time with programmable wait states, and returns a one-cycle acknowledge to the granted requester.

Parameters:
RAM_WAIT, 2, number of ACCESS-state cycles per SRAM cycle; legal range 1..15; a value of 0 is treated as 1.

Ports:
clk  input  1  system clock; all state changes on rising edge
reset  input  1  asynchronous, active-high reset
cpu_req  input  1  CPU access request; held high until cpu_ack
cpu_we  input  1  1 = write, 0 = read
cpu_addr  input  15  {field[2:0], word_addr[11:0]}
cpu_wdata  input  12  write data
cpu_rdata  output  12  read data; valid while cpu_ack is high, held until the next CPU read completes
cpu_ack  output  1  one-cycle completion pulse
dma_req  input  1  DMA access request (same rules as CPU)
dma_we  input  1  1 = write
dma_addr  input  15  DMA address
dma_wdata  input  12  DMA write data
dma_rdata  output  12  DMA read data (same rules as cpu_rdata)
dma_ack  output  1  one-cycle completion pulse
ram_a  output  18  SRAM address
ram_oe_n  output  1  SRAM output enable, active low
ram_we_n  output  1  SRAM write enable, active low
ram1_ce_n  output  1  SRAM chip enable, active low
ram1_ub_n  output  1  upper byte enable, active low
ram1_lb_n  output  1  lower byte enable, active low
ram1_io  inout  16  SRAM data bus
busy  output  1  high in any state other than IDLE

Behaviour:
- Reset (asynchronous, takes effect immediately):
  - State goes to IDLE.
  - ram_oe_n, ram_we_n, ram1_ce_n, ram1_ub_n and ram1_lb_n go to 1.
  - ram_a = 0 and ram1_io is high-Z.
  - Both acks = 0, both rdata = 0, busy = 0.
  - A reset mid-access aborts the access with no ack.
- States: IDLE -> SETUP -> ACCESS (RAM_WAIT cycles) -> DONE -> IDLE.
- IDLE:
  - Sample the requests. If either is high, grant one, latch its we/addr/wdata, and go to SETUP.
  - With no request, stay in IDLE with the strobes inactive.
- SETUP:
  - ram_a = {3'b000, addr}.
  - ce_n, ub_n and lb_n go to 0.
  - For a read, oe_n = 0. For a write, oe_n stays 1, we_n stays 1, and ram1_io is driven with {4'b0000, wdata}.
- ACCESS:
  - Address and enables are held.
  - For a write, we_n = 0 for all RAM_WAIT cycles.
  - For a read, ram1_io[11:0] is captured into the granted port's rdata on the last ACCESS cycle. Bits [15:12] are ignored.
- DONE:
  - we_n = 1 and oe_n = 1, while ce_n, ram_a and the write data are held for one cycle of hold time.
  - The granted port's ack = 1 for exactly this cycle. The next state is IDLE.
  - ram1_io returns to high-Z on entry to IDLE.
- Latency: ack is high RAM_WAIT+2 clocks after the edge on which IDLE sampled the request. Back-to-back accesses cost RAM_WAIT+3 clocks each.
- Handshake rules:
  - A requester deasserts req on the edge where it samples its ack high.
  - A req still high in IDLE starts a new access.
  - Changes to addr/wdata/we after grant have no effect on the current access.
- Arbitration (default): fixed priority, DMA over CPU, decided only in IDLE. A request arriving during SETUP/ACCESS/DONE waits for IDLE.
- Never drive ram1_io while oe_n = 0, in any state.

Optional Feature:
ARB_ROUND_ROBIN_EN:
- Defined: a last_grant flag (reset value = CPU) gives the simultaneous-request tie to the port not granted last. A lone requester is always granted.
- Undefined: fixed DMA-over-CPU priority; last_grant is not implemented.

Test Plan:
- CPU write 7654 to addr 15'o10017, RAM_WAIT=2 -> ram_a = 18'o010017; we_n low for 2 cycles; ram1_io = 16'h0FAC; cpu_ack 4 clocks after the request was sampled.
- CPU read of 15'o10017 with the SRAM model returning 16'hFFAC -> cpu_rdata = 12'o7654 with cpu_ack; dma_ack stays 0.
- cpu_req and dma_req rise together, both reads -> default: DMA served first, then CPU. With ARB_ROUND_ROBIN_EN after reset: DMA first; on the next simultaneous pair, CPU first.
- Assert reset during ACCESS of a write -> all strobes go to 1 in the same timestep; ram1_io goes high-Z; no ack; busy = 0.
- CPU holds req high for 3 consecutive accesses at RAM_WAIT=1 -> acks 4 clocks apart; oe_n and the ram1_io drive never overlap.
- RAM_WAIT=0 instance -> behaves identically to RAM_WAIT=1 (1 ACCESS cycle).
